// File: rtl/wave_capture.sv
// Audio waveform capture: decimates the L/R sample stream, arms on a rising zero
// crossing (or timeout / free-run) and fills a ping-pong bank that the display reads.
module wave_capture #(
  parameter int SAMPLE_DIV = 2083,
  parameter int DEPTH      = 256,
  parameter int STORE_W    = 8,
  parameter int TIMEOUT    = 4096,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [23:0]        audioL,
  input  logic [23:0]        audioR,
  input  logic               ch_sel,
  input  logic               trig_en,
  input  logic               frame_sync,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [STORE_W-1:0] rd_l,
  output logic [STORE_W-1:0] rd_r,
  output logic               valid,
  output logic               forced,
  output logic [1:0]         state_o
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int MEM_W = 2 * STORE_W;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [DIV_W-1:0]  div_r;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s, we_addr_s;
  logic              bank_r, valid_r, forced_r;
  logic              forced_next_r, forced_next_s;
  logic              cur_sign_r;
  logic              tick_s, crossing_s, timeout_s, we_s, swap_s;
  logic [23:0]       sel_s;
  logic [MEM_W-1:0]  wr_data_s, rd_word_s;
  logic [MEM_W-1:0]  mem_r [2*DEPTH];
  logic              unused_s;

  assign tick_s     = (div_r == DIV_W'(SAMPLE_DIV - 1));
  assign sel_s      = ch_sel ? audioR : audioL;
  // cur_sign_r holds the sign of the previous tick's sample, i.e. prev[23] at this tick
  assign crossing_s = cur_sign_r & ~sel_s[23];
  assign timeout_s  = (tmo_r == TMO_W'(TIMEOUT - 1));
  assign wr_data_s  = {audioL[23 -: STORE_W], audioR[23 -: STORE_W]};
  assign rd_word_s  = mem_r[{~bank_r, rd_addr}];
  assign unused_s   = ^{audioL[23-STORE_W:0], audioR[23-STORE_W:0], sel_s[22:0]};

  assign valid   = valid_r;
  assign forced  = forced_r;
  assign state_o = state_r;

  // Free-running capture-rate divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= DIV_W'(1'b0);
    end else if (tick_s) begin
      div_r <= DIV_W'(1'b0);
    end else begin
      div_r <= div_r + DIV_W'(1'b1);
    end
  end

  // Next-state, write strobe and swap decode
  always_comb begin
    state_s       = state_r;
    tmo_s         = tmo_r;
    wr_addr_s     = wr_addr_r;
    forced_next_s = forced_next_r;
    we_s          = 1'b0;
    we_addr_s     = wr_addr_r;
    swap_s        = 1'b0;
    case (state_r)
      ARM: begin
        if (tick_s && (!trig_en || crossing_s || timeout_s)) begin
          we_s          = 1'b1;
          we_addr_s     = ADDR_W'(1'b0);
          wr_addr_s     = ADDR_W'(1'b1);
          forced_next_s = timeout_s & ~crossing_s;
          tmo_s         = TMO_W'(1'b0);
          state_s       = CAPTURE;
        end else if (tick_s) begin
          tmo_s = tmo_r + TMO_W'(1'b1);
        end else begin
          tmo_s = tmo_r;
        end
      end
      CAPTURE: begin
        if (tick_s) begin
          we_s      = 1'b1;
          wr_addr_s = wr_addr_r + ADDR_W'(1'b1);
          if (wr_addr_r == ADDR_W'(DEPTH - 1)) begin
            state_s = DONE;
          end else begin
            state_s = CAPTURE;
          end
        end else begin
          state_s = CAPTURE;
        end
      end
      DONE: begin
        // a tick coinciding with the swap is simply never written
        if (frame_sync) begin
          swap_s  = 1'b1;
          tmo_s   = TMO_W'(1'b0);
          state_s = ARM;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = ARM;
      end
    endcase
  end

  // Control state, bank select and display status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ARM;
      tmo_r         <= TMO_W'(1'b0);
      wr_addr_r     <= ADDR_W'(1'b0);
      forced_next_r <= 1'b0;
      bank_r        <= 1'b0;
      valid_r       <= 1'b0;
      forced_r      <= 1'b0;
      cur_sign_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      tmo_r         <= tmo_s;
      wr_addr_r     <= wr_addr_s;
      forced_next_r <= forced_next_s;
      if (tick_s) begin
        cur_sign_r <= sel_s[23];
      end
      if (swap_s) begin
        bank_r   <= ~bank_r;
        valid_r  <= 1'b1;
        forced_r <= forced_next_r;
      end
    end
  end

  // Ping-pong sample memory write port
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[{bank_r, we_addr_s}] <= wr_data_s;
    end
  end

  // Registered display read port from the bank not being written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_l <= STORE_W'(1'b0);
      rd_r <= STORE_W'(1'b0);
    end else begin
      rd_l <= rd_word_s[MEM_W-1:STORE_W];
      rd_r <= rd_word_s[STORE_W-1:0];
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture with SAMPLE_DIV=4, DEPTH=16, TIMEOUT=8, STORE_W=8.
module tb_wave_capture;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] audioL, audioR;
  logic        ch_sel, trig_en, frame_sync;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_l, rd_r;
  logic        valid, forced;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  wave_capture #(
    .SAMPLE_DIV(4),
    .DEPTH     (16),
    .STORE_W   (8),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .audioL    (audioL),
    .audioR    (audioR),
    .ch_sel    (ch_sel),
    .trig_en   (trig_en),
    .frame_sync(frame_sync),
    .rd_addr   (rd_addr),
    .rd_l      (rd_l),
    .rd_r      (rd_r),
    .valid     (valid),
    .forced    (forced),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one capture period (4 cycles, ending just after a tick edge); fs_idx picks the frame_sync cycle
  task automatic period(input logic [23:0] l, input logic [23:0] r, input int fs_idx);
    audioL = l;
    audioR = r;
    for (int c = 0; c < 4; c++) begin
      frame_sync = (c == fs_idx);
      step();
    end
    frame_sync = 1'b0;
  endtask

  task automatic swap_now(input logic exp_forced);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("swap_valid", valid, 1);
    chk("swap_forced", forced, exp_forced);
    chk("swap_state", state_o, 0);
    step(); step(); step();
  endtask

  initial begin
    rst_n = 1'b0;
    frame_sync = 1'b0;
    for (int c = 0; c < 5; c++) begin
      audioL = 24'($urandom);
      audioR = 24'($urandom);
      ch_sel = 1'($urandom);
      trig_en = 1'($urandom);
      frame_sync = 1'($urandom);
      rd_addr = 4'($urandom);
      step();
    end
    chk("rst_rd_l", rd_l, 0);
    chk("rst_rd_r", rd_r, 0);
    chk("rst_valid", valid, 0);
    chk("rst_forced", forced, 0);
    chk("rst_state", state_o, 0);

    // free-run on the right channel, frame_sync pulses in ARM and CAPTURE
    trig_en = 1'b0; ch_sel = 1'b1; frame_sync = 1'b0; rd_addr = 4'd0;
    audioL = 24'hA00000; audioR = 24'h100000;
    rst_n = 1'b1;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    step(); step();
    chk("pre_first_tick_state", state_o, 0);
    step();
    chk("first_tick_state", state_o, 1);
    chk("arm_fs_valid", valid, 0);
    for (int i = 1; i < 15; i++) begin
      period(24'hA00000, 24'((32'h10 + i) << 16), (i == 5) ? 1 : -1);
    end
    chk("cap_fs_valid", valid, 0);
    chk("addr14_state", state_o, 1);
    period(24'hA00000, 24'h1F0000, -1);
    chk("free_done_state", state_o, 2);
    period(24'hA00000, 24'h7F0000, -1);
    period(24'hA00000, 24'h7F0000, -1);
    chk("done_hold_state", state_o, 2);
    chk("done_hold_valid", valid, 0);

    // show the free-run bank, with trigger armed on a negative left channel
    trig_en = 1'b1; ch_sel = 1'b0; audioL = 24'hF00000; audioR = 24'h000000;
    swap_now(1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      chk("free_rd_r", rd_r, 32'h10 + i);
      chk("free_rd_l", rd_l, 32'hA0);
    end
    chk("neg_hold_state", state_o, 0);

    // rising crossing then +0x010000 ramp
    period(24'h200000, 24'h000000, -1);
    chk("cross_trig_state", state_o, 1);
    for (int j = 1; j < 15; j++) begin
      period(24'((32'h20 + j) << 16), 24'h000000, -1);
    end
    chk("cross_addr14_state", state_o, 1);
    period(24'h2F0000, 24'h000000, -1);
    chk("cross_done_state", state_o, 2);

    // swap coincident with a tick; read on the swap edge still sees the old bank
    rd_addr = 4'd0;
    period(24'h400000, 24'h330000, 3);
    chk("coin_state", state_o, 0);
    chk("coin_valid", valid, 1);
    chk("coin_forced", forced, 0);
    chk("coin_old_bank_rd", rd_l, 32'hA0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      chk("cross_rd_l", rd_l, 32'h20 + i);
    end

    // timeout: 4 ARM ticks elapsed during the reads, forced trigger on the 8th
    period(24'h400000, 24'h330000, -1);
    period(24'h400000, 24'h330000, -1);
    period(24'h400000, 24'h330000, -1);
    chk("tmo_7th_state", state_o, 0);
    period(24'h400000, 24'h330000, -1);
    chk("tmo_8th_state", state_o, 1);
    for (int i = 1; i < 16; i++) begin
      period(24'h400000, 24'h330000, -1);
    end
    chk("tmo_done_state", state_o, 2);
    chk("tmo_pre_swap_forced", forced, 0);
    swap_now(1'b1);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      chk("tmo_rd_l", rd_l, 32'h40);
      chk("tmo_rd_r", rd_r, 32'h33);
    end

    // free-run partial capture to wr_addr 7, then async reset
    trig_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      period(24'h550000, 24'h550000, -1);
    end
    chk("mid_cap_state", state_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_forced", forced, 0);
    chk("mid_rst_rd_l", rd_l, 0);
    chk("mid_rst_rd_r", rd_r, 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      period(24'((32'h60 + i) << 16), 24'((32'h70 + i) << 16), -1);
    end
    chk("post_rst_done_state", state_o, 2);
    swap_now(1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step();
      chk("post_rst_rd_l", rd_l, 32'h60 + i);
      chk("post_rst_rd_r", rd_r, 32'h70 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
